// File: rtl/fns_cac_pkg.sv
// Shared constants and elaboration-time helpers for the FNS crosstalk-avoidance encoder.
package fns_cac_pkg;

    localparam logic MODE_FTF   = 1'b0;
    localparam logic MODE_TRANS = 1'b1;

    // Fibonacci number with F(0)=0, F(1)=F(2)=1.
    function automatic int fib(input int k);
        int a;
        int b;
        int t;
        if (k <= 0) return 0;
        a = 1;
        b = 1;
        for (int i = 3; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Largest value representable by a code_w-bit FNS codeword (sum of F(1)..F(code_w)).
    function automatic int fns_sum_max(input int code_w);
        return fib(code_w + 2) - 1;
    endfunction

endpackage

// File: rtl/fns_cac_encoder_pipe_if.sv
// Valid/ready source and sink bus of the FNS encoder.
interface fns_cac_encoder_pipe_if #(
    parameter int DATA_W = 5,
    parameter int CODE_W = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_code
    );
endinterface

// File: rtl/fns_stage.sv
// One FNS digit: decide bit k from the running remainder and strip its weight.
module fns_stage
    import fns_cac_pkg::*;
#(
    parameter int CODE_W = 7,
    parameter int K      = 2
) (
    input  logic [CODE_W:0] r,
    input  logic            hi_bit,
    input  logic            prev_bit,
    input  logic            mode,
    output logic            d,
    output logic [CODE_W:0] r_next
);
    localparam int RW = CODE_W + 1;
    localparam logic [CODE_W:0] W_LO = RW'(fib(K));
    localparam logic [CODE_W:0] W_HI = RW'(fib(K + 1));

    // Forced digits first; the ambiguous band [F(k), F(k+1)) is free and settled by mode.
    always_comb begin
        d = 1'b0;
        if (r >= W_HI) begin
            d = 1'b1;
        end else if (r < W_LO) begin
            d = 1'b0;
        end else begin
            case (mode)
                MODE_FTF:   d = hi_bit;
                MODE_TRANS: d = prev_bit;
                default:    d = hi_bit;
            endcase
        end
        r_next = d ? (r - W_LO) : r;
    end
endmodule

// File: rtl/fns_cac_encoder_pipe.sv
// Registered binary-to-FNS encoder with valid/ready handshake and bus toggle counter.
module fns_cac_encoder_pipe
    import fns_cac_pkg::*;
#(
    parameter int DATA_W = 5,
    parameter int CODE_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fns_cac_encoder_pipe_if.slave bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      toggle_cnt
);
    localparam int RW = CODE_W + 1;
    localparam int PW = $clog2(CODE_W + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    if (((longint'(1) << DATA_W) - 1) > longint'(fns_sum_max(CODE_W))) begin : g_range_err
        $error("fns_cac_encoder_pipe: DATA_W values exceed CODE_W-bit FNS range");
    end

    // Saturating add of the number of flipped bus lines.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [CODE_W-1:0] flips);
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'($countones(flips));
        if (sum > SW'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    logic              ready;
    logic              accept;
    logic [CODE_W-1:0] code_p0;
    logic [CODE_W-1:0] code_p1;
    logic              vld_p1;

    assign ready         = !vld_p1 | bus.out_ready;
    assign accept        = bus.in_valid & ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_code  = code_p1;

    // ---- stage p0: combinational MSB-first encode of the incoming word ----
    // code_p1 always equals the last word driven onto the bus, so it doubles as prev_code.
    for (genvar k = CODE_W; k >= 2; k--) begin : g_stage
        logic            d;
        logic            hi;
        logic [CODE_W:0] r_in;
        logic [CODE_W:0] r_out;

        if (k == CODE_W) begin : g_top
            assign r_in = RW'(bus.in_data);
            assign hi   = 1'b0;
        end else begin : g_mid
            assign r_in = g_stage[k+1].r_out;
            assign hi   = g_stage[k+1].d;
        end

        fns_stage #(.CODE_W(CODE_W), .K(k)) u_stage (
            .r        (r_in),
            .hi_bit   (hi),
            .prev_bit (code_p1[k-1]),
            .mode     (bus.in_mode),
            .d        (d),
            .r_next   (r_out)
        );

        assign code_p0[k-1] = d;
    end

    // Remainder after bit 2 is only ever 0 or 1, so OR-reducing it is the F(1) digit.
    assign code_p0[0] = |g_stage[2].r_out;

    // ---- stage p1: output register; holds code while stalled or idle ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            code_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            code_p1 <= code_p0;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Accumulate line toggles per load; a coincident clear restarts from this load's count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_cnt <= '0;
        end else if (accept) begin
            toggle_cnt <= sat_add(cnt_clr ? '0 : toggle_cnt, code_p0 ^ code_p1);
        end else if (cnt_clr) begin
            toggle_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_fns_cac_encoder_pipe.sv
// Randomized and directed bench for fns_cac_encoder_pipe against a behavioural FNS model.
module tb_fns_cac_encoder_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_clr;
    logic [15:0] toggle_cnt;
    logic [2:0]  toggle_cnt3;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic       m_vld;
    logic [6:0] m_code;
    int         m_data;
    int         m_cnt16;
    int         m_cnt3;

    fns_cac_encoder_pipe_if #(.DATA_W(5), .CODE_W(7)) bus ();
    fns_cac_encoder_pipe_if #(.DATA_W(5), .CODE_W(7)) bus3 ();

    assign bus3.in_valid  = bus.in_valid;
    assign bus3.in_data   = bus.in_data;
    assign bus3.in_mode   = bus.in_mode;
    assign bus3.out_ready = bus.out_ready;

    fns_cac_encoder_pipe #(.DATA_W(5), .CODE_W(7), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt)
    );

    fns_cac_encoder_pipe #(.DATA_W(5), .CODE_W(7), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt3)
    );

    always #5 clk = ~clk;

    function automatic int fibn(input int k);
        int a;
        int b;
        int t;
        if (k <= 0) return 0;
        a = 1;
        b = 1;
        for (int i = 3; i <= k; i++) begin
            t = a + b; a = b; b = t;
        end
        return b;
    endfunction

    // Digit rules applied to plain integers, MSB first.
    function automatic logic [6:0] ref_encode(input int v, input logic mode, input logic [6:0] prev);
        int r;
        logic [6:0] c;
        logic b;
        r = v;
        c = '0;
        for (int k = 7; k >= 2; k--) begin
            if (r >= fibn(k + 1)) b = 1'b1;
            else if (r < fibn(k)) b = 1'b0;
            else if (mode) b = prev[k-1];
            else b = (k == 7) ? 1'b0 : c[k];
            c[k-1] = b;
            if (b) r = r - fibn(k);
        end
        c[0] = (r == 1);
        return c;
    endfunction

    function automatic int wsum(input logic [6:0] c);
        int s;
        s = 0;
        for (int k = 1; k <= 7; k++) if (c[k-1]) s += fibn(k);
        return s;
    endfunction

    function automatic logic ftf_ok(input logic [6:0] c);
        for (int i = 0; i <= 4; i++)
            if (c[i+2 -: 3] == 3'b010 || c[i+2 -: 3] == 3'b101) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int sat(input int a, input int b, input int mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_code = '0; m_data = 0; m_cnt16 = 0; m_cnt3 = 0;
    endtask

    // Advance one clock edge, predicting the transfer from bench-driven inputs and model state.
    task automatic cycle();
        logic acc;
        logic [6:0] nc;
        int pc;
        int d;
        acc = bus.in_valid && (!m_vld || bus.out_ready);
        d   = int'(bus.in_data);
        nc  = ref_encode(d, bus.in_mode, m_code);
        pc  = $countones(nc ^ m_code);
        @(posedge clk);
        if (acc) begin
            m_cnt16 = sat(cnt_clr ? 0 : m_cnt16, pc, 65535);
            m_cnt3  = sat(cnt_clr ? 0 : m_cnt3, pc, 7);
            m_code  = nc;
            m_data  = d;
            m_vld   = 1'b1;
        end else begin
            if (bus.out_ready) m_vld = 1'b0;
            if (cnt_clr) begin m_cnt16 = 0; m_cnt3 = 0; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input int v, input logic mode);
        bus.in_valid = 1'b1; bus.in_data = 5'(v); bus.in_mode = mode; bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_code !== 7'd0) $display("FAIL reset_code: got %b want 0000000", bus.out_code); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", toggle_cnt); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        send(31, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_code !== 7'b1111100) $display("FAIL basic_code31: got %b want 1111100", bus.out_code); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd5) $display("FAIL basic_cnt: got %0d want 5", toggle_cnt); else n_pass++;
    endtask

    task automatic test_ftf_sweep();
        send(8, 1'b0);
        n_checks++; if (bus.out_code !== 7'b0011000) $display("FAIL ftf_code8: got %b want 0011000", bus.out_code); else n_pass++;
        send(13, 1'b0);
        n_checks++; if (bus.out_code !== 7'b0110000) $display("FAIL ftf_code13: got %b want 0110000", bus.out_code); else n_pass++;
        for (int v = 0; v < 32; v++) begin
            bus.in_valid = 1'b1; bus.in_data = 5'(v); bus.in_mode = 1'b0; bus.out_ready = 1'b1;
            cycle();
            n_checks++; if (bus.out_code !== m_code) $display("FAIL sweep_code v=%0d: got %b want %b", v, bus.out_code, m_code); else n_pass++;
            n_checks++; if (wsum(bus.out_code) != v) $display("FAIL sweep_sum v=%0d: got %0d want %0d", v, wsum(bus.out_code), v); else n_pass++;
            n_checks++; if (!ftf_ok(bus.out_code)) $display("FAIL sweep_ftf v=%0d: got %b want no 010/101", v, bus.out_code); else n_pass++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (toggle_cnt !== 16'(m_cnt16)) $display("FAIL sweep_cnt: got %0d want %0d", toggle_cnt, m_cnt16); else n_pass++;
    endtask

    task automatic test_trans_mode();
        do_reset();
        send(13, 1'b1);
        n_checks++; if (bus.out_code !== 7'b0101011) $display("FAIL trans_code13: got %b want 0101011", bus.out_code); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd4) $display("FAIL trans_cnt13: got %0d want 4", toggle_cnt); else n_pass++;
        send(13, 1'b0);
        send(8, 1'b1);
        n_checks++; if (bus.out_code !== 7'b0100000) $display("FAIL trans_code8a: got %b want 0100000", bus.out_code); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd9) $display("FAIL trans_cnt8a: got %0d want 9", toggle_cnt); else n_pass++;
        send(8, 1'b1);
        n_checks++; if (bus.out_code !== 7'b0100000) $display("FAIL trans_code8b: got %b want 0100000", bus.out_code); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd9) $display("FAIL trans_cnt8b: got %0d want 9", toggle_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        logic [6:0] held;
        send(19, 1'b0);
        held = m_code;
        bus.out_ready = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready0: got %b want 0", bus.in_ready); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 5'($urandom_range(0, 31));
            bus.in_mode  = 1'($urandom_range(0, 1));
            cycle();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== held)
                $display("FAIL stall_hold %0d: got v=%b %b want v=1 %b", i, bus.out_valid, bus.out_code, held); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready %0d: got %b want 0", i, bus.in_ready); else n_pass++;
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 5'd6; bus.in_mode = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", bus.in_ready); else n_pass++;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== m_code)
            $display("FAIL release_load: got v=%b %b want v=1 %b", bus.out_valid, bus.out_code, m_code); else n_pass++;
        bus.in_data = 5'd27;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== m_code)
            $display("FAIL b2b_load: got v=%b %b want v=1 %b", bus.out_valid, bus.out_code, m_code); else n_pass++;
        bus.in_valid = 1'b0;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_code !== m_code)
            $display("FAIL drain: got v=%b %b want v=0 %b", bus.out_valid, bus.out_code, m_code); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send((i % 2 == 0) ? 31 : 0, 1'b0);
            n_checks++; if (toggle_cnt3 !== 3'(m_cnt3)) $display("FAIL sat_cnt3 %0d: got %0d want %0d", i, toggle_cnt3, m_cnt3); else n_pass++;
        end
        n_checks++; if (toggle_cnt3 !== 3'd7) $display("FAIL sat_cnt3_final: got %0d want 7", toggle_cnt3); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd30) $display("FAIL sat_cnt16_final: got %0d want 30", toggle_cnt); else n_pass++;
        cnt_clr = 1'b1;
        send(31, 1'b0);
        n_checks++; if (toggle_cnt3 !== 3'd5) $display("FAIL clr_load_cnt3: got %0d want 5", toggle_cnt3); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd5) $display("FAIL clr_load_cnt16: got %0d want 5", toggle_cnt); else n_pass++;
        cycle();
        cnt_clr = 1'b0;
        n_checks++; if (toggle_cnt !== 16'd0 || toggle_cnt3 !== 3'd0)
            $display("FAIL clr_alone: got %0d/%0d want 0/0", toggle_cnt, toggle_cnt3); else n_pass++;
    endtask

    task automatic test_async_reset();
        send(13, 1'b0);
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        n_checks++; if (bus.out_code !== 7'b0110000) $display("FAIL prestall_code: got %b want 0110000", bus.out_code); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_code !== 7'd0 || toggle_cnt !== 16'd0 || toggle_cnt3 !== 3'd0)
            $display("FAIL async_rst: got v=%b %b cnt=%0d want v=0 0000000 cnt=0", bus.out_valid, bus.out_code, toggle_cnt); else n_pass++;
        #2;
        rst = 1'b0;
        model_reset();
        send(13, 1'b1);
        n_checks++; if (bus.out_code !== 7'b0101011) $display("FAIL post_rst_code: got %b want 0101011", bus.out_code); else n_pass++;
        n_checks++; if (toggle_cnt !== 16'd4) $display("FAIL post_rst_cnt: got %0d want 4", toggle_cnt); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_mode   = 1'($urandom_range(0, 1));
            bus.in_data   = 5'($urandom_range(0, 31));
            cnt_clr       = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++; if (bus.in_ready !== (!m_vld || bus.out_ready))
                $display("FAIL rnd_ready %0d: got %b want %b", i, bus.in_ready, (!m_vld || bus.out_ready)); else n_pass++;
            cycle();
            n_checks++; if (bus.out_valid !== m_vld || bus.out_code !== m_code)
                $display("FAIL rnd_out %0d: got v=%b %b want v=%b %b", i, bus.out_valid, bus.out_code, m_vld, m_code); else n_pass++;
            n_checks++; if (toggle_cnt !== 16'(m_cnt16) || toggle_cnt3 !== 3'(m_cnt3))
                $display("FAIL rnd_cnt %0d: got %0d/%0d want %0d/%0d", i, toggle_cnt, toggle_cnt3, m_cnt16, m_cnt3); else n_pass++;
            if (m_vld) begin
                n_checks++; if (wsum(bus.out_code) != m_data)
                    $display("FAIL rnd_sum %0d: got %0d want %0d", i, wsum(bus.out_code), m_data); else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0; bus.out_ready = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_ftf_sweep();
        test_trans_mode();
        test_stall();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fns_cac_encoder_pipe.md
Name: fns_cac_encoder_pipe

Overview:
- Parametrised, registered successor to the combinational 5-bit IFNS encoder.
- Maps a DATA_W-bit binary word onto a CODE_W-bit Fibonacci-numeral-system (FNS) codeword for on-chip bus crosstalk avoidance.
- Adds a valid/ready handshake, an output register, runtime mode selection (FTF-compliant or transition-minimising), and a saturating bus-toggle counter.
- Sits between the data source and the bus driver.

Parameters:
DATA_W, 5, binary input width; elaboration error unless 2^DATA_W-1 <= F(CODE_W+2)-1
CODE_W, 7, codeword width; bit k (1..CODE_W) carries weight F(k), with F(1)=F(2)=1
CNT_W, 16, toggle counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/in_mode valid
in_ready  output  1  block accepts a word this cycle
in_data  input  DATA_W  binary value
in_mode  input  1  0 = FTF (forbidden-transition-free), 1 = transition-minimising; sampled with in_data
out_valid  output  1  out_code valid
out_ready  input  1  downstream accepts out_code
out_code  output  CODE_W  codeword, bit CODE_W-1 = FNS bit k=CODE_W
toggle_cnt  output  CNT_W  accumulated bus bit toggles
cnt_clr  input  1  synchronous clear of toggle_cnt

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, out_code=0, prev_code=0, toggle_cnt=0. In-flight word discarded.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
- On accept: encode in the same cycle, load out_code, set out_valid=1. Latency is 1 cycle from accept to out_valid.
- If out_valid & out_ready & !accept: out_valid -> 0 and out_code holds its value.
- Back-to-back acceptance gives full throughput.
- out_code is stable while out_valid & !out_ready.
- Encoding proceeds MSB first on remainder r, with r initially in_data zero-extended. For stage k = CODE_W down to 2:
  - r >= F(k+1): d_k=1
  - r < F(k): d_k=0
  - otherwise the bit is ambiguous and is resolved by mode:
    - mode 0: d_k = d_(k+1); for k=CODE_W, d_k=0.
    - mode 1: d_k = prev_code bit k.
  - Then r = r - d_k*F(k).
- Final stage: d_1 = r (r is 0 or 1 by construction).
- prev_code register: updated to the new code on every out_code load. It holds the last word placed on the bus, not the last word consumed.
- Toggle counting: on each load, toggle_cnt += popcount(new_code ^ prev_code).
  - Saturates at 2^CNT_W-1 and never wraps.
  - Simultaneous cnt_clr and load: toggle_cnt = popcount of that load (clear first, then add).
  - cnt_clr alone: toggle_cnt = 0.
- Widths: internal remainder and weight constants are CODE_W+1 bits wide; no truncation is allowed.
- Invariant: the sum of weights of the set bits of out_code equals the accepted in_data.
- Mode 0 output never contains the 010 or 101 bit patterns (FTF property).

Decomposition:
- Package fns_cac_pkg holds:
  - constant function fib(k);
  - function fns_sum_max(CODE_W);
  - mode encoding constants MODE_FTF=0, MODE_TRANS=1.
- One sub-module fns_stage holds the per-bit compare/subtract/ambiguity resolve logic, with inputs r, higher bit, previous bit and mode, and outputs d and r_next. It is instantiated CODE_W-1 times via generate; bit 1 is plain wiring.

Test Plan:
1. Reset then mode0, in_data=31 -> next cycle out_valid=1, out_code=1111100, toggle_cnt=5.
2. Mode0, in_data=8 -> out_code=0011000. Mode0, in_data=13 -> out_code=0110000. Sweep mode0 over 0..31 -> weighted sum equals input and no 010/101 pattern appears.
3. After reset (prev_code=0000000), mode1, in_data=13 -> out_code=0101011, toggle_cnt += 4. Then mode1, in_data=8 with prev_code=0100000 (seed by sending mode1 in_data=8 after mode1 in_data=8) -> out_code=0100000 and 0 toggles added.
4. Hold out_ready=0 with out_valid=1 -> in_ready=0, out_code stable for 5 cycles, extra in_valid pulses ignored. Release out_ready together with in_valid -> the new word loads in the same cycle and no bubble occurs.
5. CNT_W=3, alternate in_data 31 and 0 in mode0 -> toggle_cnt saturates at 7. cnt_clr asserted coincident with a 5-toggle load -> toggle_cnt=5.
6. Assert rst asynchronously mid-stall (between clock edges) -> out_valid, out_code and toggle_cnt reach 0 immediately. The next accepted mode1 word is encoded against prev_code=0.
